// File: rtl/uart_rx_framed.sv
// Framed UART receiver: runtime baud divisor, optional parity, 1/2 stop bits, error flags
// and a ready/valid holding register fed from a 2FF-synchronised rx pin.
module uart_rx_framed #(
    parameter int DATA_BITS    = 8,
    parameter int DIVISOR_BITS = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx_i,
    input  logic [DIVISOR_BITS-1:0] divisor_i,
    input  logic [1:0]              parity_i,
    input  logic                    two_stop_i,
    output logic [DATA_BITS-1:0]    data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    parity_err_o,
    output logic                    frame_err_o,
    output logic                    break_o,
    output logic                    overrun_o,
    output logic                    busy_o
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic                    rx_meta_q, rx_sync_q;
    logic [2:0]              state_q, state_d;
    logic [DIVISOR_BITS-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [1:0]              par_mode_q, par_mode_d;
    logic                    two_stop_q, two_stop_d;
    logic [3:0]              bit_q, bit_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic                    par_bit_q, par_bit_d;
    logic                    ferr_q, ferr_d;
    logic [DATA_BITS-1:0]    data_q, data_d;
    logic                    valid_q, valid_d, perr_q, perr_d, fe_q, fe_d;
    logic                    brk_q, brk_d, ovr_q, ovr_d;
    logic                    tick, par_en, load;
    logic                    frame_perr, frame_ferr, frame_brk;

    assign tick   = (cnt_q == '0);
    assign par_en = par_mode_q[0] ^ par_mode_q[1];

    // Only meaningful on the last stop sample, where rx_sync_q is that sample.
    assign frame_ferr = ferr_q | ~rx_sync_q;
    assign frame_perr = par_en & (^{shift_q, par_bit_q} ^ par_mode_q[1]);
    assign frame_brk  = frame_ferr & (shift_q == '0) & (~par_en | ~par_bit_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        par_mode_d = par_mode_q;
        two_stop_d = two_stop_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        ferr_d     = ferr_q;
        load       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    state_d    = S_START;
                    cnt_d      = (divisor_i >> 1) - 1'b1;
                    div_d      = divisor_i;
                    par_mode_d = parity_i;
                    two_stop_d = two_stop_i;
                    bit_d      = '0;
                    par_bit_d  = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = div_q - 1'b1;
                    case (state_q)
                        S_START: state_d = rx_sync_q ? S_IDLE : S_DATA;
                        S_DATA: begin
                            shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                            if (bit_q == 4'(DATA_BITS - 1)) begin
                                bit_d   = '0;
                                state_d = par_en ? S_PARITY : S_STOP;
                            end else begin
                                bit_d = bit_q + 4'd1;
                            end
                        end
                        S_PARITY: begin
                            par_bit_d = rx_sync_q;
                            state_d   = S_STOP;
                        end
                        S_STOP: begin
                            ferr_d = frame_ferr;
                            if (two_stop_q && bit_q == 4'd0) begin
                                bit_d = 4'd1;
                            end else begin
                                load    = 1'b1;
                                state_d = rx_sync_q ? S_IDLE : S_WAIT_HIGH;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Holding register: a load in the same cycle as an accept wins and is not an overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        fe_d    = fe_q;
        brk_d   = brk_q;
        ovr_d   = ovr_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            fe_d    = 1'b0;
            brk_d   = 1'b0;
            ovr_d   = 1'b0;
        end
        if (load) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = frame_perr;
            fe_d    = frame_ferr;
            brk_d   = frame_brk;
            ovr_d   = valid_q & ~ready_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            par_mode_q <= '0;
            two_stop_q <= 1'b0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            par_mode_q <= par_mode_d;
            two_stop_q <= two_stop_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            fe_q       <= fe_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = fe_q;
    assign break_o      = brk_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: wire-level frame driver, word monitor and a frame-rule reference model.
`timescale 1ns/1ps
module tb_uart_rx_framed;
    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
        logic       ovr;
    } word_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx8, rx7, ready8, ready7;
    logic [15:0] divisor;
    logic [1:0]  parity;
    logic        two_stop;
    logic [7:0]  data8;
    logic [6:0]  data7;
    logic        valid8, pe8, fe8, brk8, ovr8, busy8;
    logic        valid7, pe7, fe7, brk7, ovr7, busy7;

    int    vectors = 0;
    int    miscompares = 0;
    word_t got8[$];
    word_t got7[$];
    time   rise8_t = 0;
    logic  v8_prev = 1'b0;

    always #5 clock = ~clock;

    uart_rx_framed #(.DATA_BITS(8), .DIVISOR_BITS(16)) u8 (
        .clock(clock), .reset(reset), .rx_i(rx8), .divisor_i(divisor), .parity_i(parity),
        .two_stop_i(two_stop), .data_o(data8), .valid_o(valid8), .ready_i(ready8),
        .parity_err_o(pe8), .frame_err_o(fe8), .break_o(brk8), .overrun_o(ovr8), .busy_o(busy8)
    );

    uart_rx_framed #(.DATA_BITS(7), .DIVISOR_BITS(16)) u7 (
        .clock(clock), .reset(reset), .rx_i(rx7), .divisor_i(divisor), .parity_i(parity),
        .two_stop_i(two_stop), .data_o(data7), .valid_o(valid7), .ready_i(ready7),
        .parity_err_o(pe7), .frame_err_o(fe7), .break_o(brk7), .overrun_o(ovr7), .busy_o(busy7)
    );

    // Every accepted word (valid & ready at a sample point) goes to the scoreboard.
    always @(negedge clock) begin
        word_t w;
        if (valid8 && !v8_prev) rise8_t = $time;
        v8_prev = valid8;
        if (valid8 && ready8) begin
            w.data = {1'b0, data8}; w.pe = pe8; w.fe = fe8; w.brk = brk8; w.ovr = ovr8;
            got8.push_back(w);
        end
        if (valid7 && ready7) begin
            w.data = {2'b0, data7}; w.pe = pe7; w.fe = fe7; w.brk = brk7; w.ovr = ovr7;
            got7.push_back(w);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: the word a frame should produce, straight from the framing rules.
    function automatic word_t model(input int dbits, input logic [8:0] data, input logic [1:0] mode,
                                    input logic pbit, input logic s1, input logic s2, input logic two);
        word_t w;
        logic [8:0] d;
        bit pen;
        d     = data & 9'((1 << dbits) - 1);
        pen   = (mode == 2'b01) || (mode == 2'b10);
        w.data = d;
        w.pe  = pen && ((($countones(d) + int'(pbit)) % 2) != ((mode == 2'b10) ? 1 : 0));
        w.fe  = !s1 || (two && !s2);
        w.brk = w.fe && (d == 9'd0) && (!pen || !pbit);
        w.ovr = 1'b0;
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; drives each wire bit for d clocks.
    task automatic send_frame(input bit sel7, input int d, input int dbits, input logic [8:0] data,
                              input logic [1:0] mode, input logic pbit, input logic s1,
                              input logic s2, input logic two);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < dbits; i++) bits.push_back(data[i]);
        if (mode == 2'b01 || mode == 2'b10) bits.push_back(pbit);
        bits.push_back(s1);
        if (two) bits.push_back(s2);
        divisor = 16'(d); parity = mode; two_stop = two;
        foreach (bits[i]) begin
            if (sel7) rx7 = bits[i]; else rx8 = bits[i];
            repeat (d) @(negedge clock);
        end
        if (sel7) rx7 = 1'b1; else rx8 = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if ({data8, valid8, pe8, fe8, brk8, ovr8, busy8} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_u8: got %h want 0", {data8, valid8, pe8, fe8, brk8, ovr8, busy8});
        end
        vectors++;
        if ({data7, valid7, pe7, fe7, brk7, ovr7, busy7} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_u7: got %h want 0", {data7, valid7, pe7, fe7, brk7, ovr7, busy7});
        end
        reset = 1'b0;
        idle(4);
    endtask

    task automatic test_basic;
        time t_start;
        int  lat;
        word_t w, e;
        t_start = $time;
        send_frame(0, 8, 8, 9'h0A5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(8);
        lat = int'((rise8_t - t_start) / 10);
        vectors++;
        if (lat !== 2 + 4 + 9 * 8 + 1) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d want %0d", lat, 2 + 4 + 9 * 8 + 1);
        end
        e = model(8, 9'h0A5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (got8.size() != 1) begin
            miscompares++;
            $display("FAIL basic_count: got %0d words want 1", got8.size());
        end else begin
            w = got8.pop_front();
            if (w !== e) begin
                miscompares++;
                $display("FAIL basic_word: got %h want %h", w, e);
            end
        end
        got8.delete();
    endtask

    task automatic test_random;
        word_t w, e;
        for (int i = 0; i < 10; i++) begin
            bit sel7;
            int d, db;
            logic [8:0] data;
            logic [1:0] mode;
            logic pbit, s1, s2, two;
            sel7 = i[0];
            db   = sel7 ? 7 : 8;
            d    = $urandom_range(20, 4);
            data = 9'($urandom);
            mode = 2'($urandom);
            pbit = 1'($urandom);
            s1   = ($urandom_range(3, 0) != 0);
            s2   = ($urandom_range(3, 0) != 0);
            two  = 1'($urandom);
            e = model(db, data, mode, pbit, s1, s2, two);
            send_frame(sel7, d, db, data, mode, pbit, s1, s2, two);
            idle(2 * d);
            vectors++;
            if ((sel7 ? got7.size() : got8.size()) != 1) begin
                miscompares++;
                $display("FAIL random_count[%0d]: got %0d words want 1", i,
                         sel7 ? got7.size() : got8.size());
            end else begin
                w = sel7 ? got7.pop_front() : got8.pop_front();
                if (w !== e) begin
                    miscompares++;
                    $display("FAIL random_word[%0d]: got %h want %h (D=%0d mode=%0d)", i, w, e, d, mode);
                end
            end
            got7.delete();
            got8.delete();
        end
    endtask

    task automatic test_parity;
        word_t w, e;
        logic [8:0]  dv[3] = '{9'h003, 9'h003, 9'h007};
        logic [1:0]  mv[3] = '{2'b01, 2'b01, 2'b10};
        logic        pv[3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            e = model(8, dv[i], mv[i], pv[i], 1'b1, 1'b1, 1'b0);
            send_frame(0, 16, 8, dv[i], mv[i], pv[i], 1'b1, 1'b1, 1'b0);
            idle(32);
            vectors++;
            if (got8.size() != 1) begin
                miscompares++;
                $display("FAIL parity_count[%0d]: got %0d words want 1", i, got8.size());
            end else begin
                w = got8.pop_front();
                if (w !== e) begin
                    miscompares++;
                    $display("FAIL parity_word[%0d]: got %h want %h", i, w, e);
                end
            end
            got8.delete();
        end
    endtask

    task automatic test_frame_break;
        word_t w, e;
        e = model(8, 9'h055, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(0, 16, 8, 9'h055, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(32);
        vectors++;
        if (got8.size() != 1) begin
            miscompares++;
            $display("FAIL frame_count: got %0d words want 1", got8.size());
        end else begin
            w = got8.pop_front();
            if (w !== e) begin
                miscompares++;
                $display("FAIL frame_word: got %h want %h", w, e);
            end
        end
        got8.delete();
        e = model(8, 9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        rx8 = 1'b0;
        idle(20 * 16);
        vectors++;
        if (busy8 !== 1'b1) begin
            miscompares++;
            $display("FAIL break_busy: got %b want 1", busy8);
        end
        vectors++;
        if (got8.size() != 1) begin
            miscompares++;
            $display("FAIL break_count: got %0d words want 1", got8.size());
        end else begin
            w = got8.pop_front();
            if (w !== e) begin
                miscompares++;
                $display("FAIL break_word: got %h want %h", w, e);
            end
        end
        rx8 = 1'b1;
        idle(48);
        vectors++;
        if (got8.size() != 0 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL break_release: got %0d words busy %b want 0 words busy 0", got8.size(), busy8);
        end
        got8.delete();
    endtask

    task automatic test_overrun;
        ready8 = 1'b0;
        send_frame(0, 8, 8, 9'h011, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(8);
        send_frame(0, 8, 8, 9'h022, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(8);
        vectors++;
        if ({valid8, data8, pe8, fe8, brk8, ovr8} !== {1'b1, 8'h22, 4'b0001}) begin
            miscompares++;
            $display("FAIL overrun_hold: got %h want %h", {valid8, data8, pe8, fe8, brk8, ovr8},
                     {1'b1, 8'h22, 4'b0001});
        end
        #1 ready8 = 1'b1;
        @(posedge clock);
        #1 ready8 = 1'b0;
        @(negedge clock);
        vectors++;
        if ({valid8, data8, pe8, fe8, brk8, ovr8} !== {1'b0, 8'h22, 4'b0000}) begin
            miscompares++;
            $display("FAIL overrun_accept: got %h want %h", {valid8, data8, pe8, fe8, brk8, ovr8},
                     {1'b0, 8'h22, 4'b0000});
        end
        #1 ready8 = 1'b1;
        idle(4);
        got8.delete();
    endtask

    // Second word loads on the very edge the first one is accepted.
    task automatic test_back_to_back;
        word_t w;
        ready8 = 1'b0;
        send_frame(0, 8, 8, 9'h011, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        fork
            send_frame(0, 8, 8, 9'h022, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
            begin
                repeat (78) @(negedge clock);
                #2 ready8 = 1'b1;
                @(negedge clock);
                #1;
                vectors++;
                if (got8.size() != 1) begin
                    miscompares++;
                    $display("FAIL b2b_count: got %0d words want 1", got8.size());
                end else begin
                    w = got8.pop_front();
                    if (w !== {9'h022, 4'b0000}) begin
                        miscompares++;
                        $display("FAIL b2b_word: got %h want %h", w, {9'h022, 4'b0000});
                    end
                end
            end
        join
        idle(8);
        got8.delete();
    endtask

    task automatic test_false_start;
        divisor = 16'd16; parity = 2'b00; two_stop = 1'b0;
        rx8 = 1'b0;
        idle(4);
        rx8 = 1'b1;
        vectors++;
        if (busy8 !== 1'b1) begin
            miscompares++;
            $display("FAIL false_busy_on: got %b want 1", busy8);
        end
        idle(6);
        vectors++;
        if (busy8 !== 1'b1) begin
            miscompares++;
            $display("FAIL false_busy_pre: got %b want 1", busy8);
        end
        idle(1);
        vectors++;
        if (busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL false_busy_off: got %b want 0", busy8);
        end
        idle(40);
        vectors++;
        if (got8.size() != 0 || valid8 !== 1'b0) begin
            miscompares++;
            $display("FAIL false_word: got %0d words want 0", got8.size());
        end
        got8.delete();
    endtask

    task automatic test_reset_mid;
        word_t w, e;
        logic [7:0] pat;
        pat = 8'h3C;
        divisor = 16'd8; parity = 2'b00; two_stop = 1'b0;
        rx8 = 1'b0; rx7 = 1'b0;
        idle(8);
        for (int i = 0; i < 3; i++) begin
            rx8 = pat[i]; rx7 = pat[i];
            idle(8);
        end
        rx8 = pat[3]; rx7 = pat[3];
        idle(4);
        reset = 1'b1; rx8 = 1'b1; rx7 = 1'b1;
        @(negedge clock);
        vectors++;
        if ({busy8, valid8, busy7, valid7} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid: got %b want 0000", {busy8, valid8, busy7, valid7});
        end
        reset = 1'b0;
        idle(48);
        vectors++;
        if (got8.size() != 0 || got7.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_words: got %0d/%0d words want 0/0", got8.size(), got7.size());
        end
        e = model(7, 9'h096, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(1, 8, 7, 9'h096, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(16);
        vectors++;
        if (got7.size() != 1) begin
            miscompares++;
            $display("FAIL seven_count: got %0d words want 1", got7.size());
        end else begin
            w = got7.pop_front();
            if (w !== e || w.data !== 9'h016) begin
                miscompares++;
                $display("FAIL seven_word: got %h want %h", w, e);
            end
        end
    endtask

    initial begin
        rx8 = 1'b1; rx7 = 1'b1; ready8 = 1'b1; ready7 = 1'b1;
        divisor = 16'd8; parity = 2'b00; two_stop = 1'b0; reset = 1'b1;
        test_reset;
        test_basic;
        test_random;
        test_parity;
        test_frame_break;
        test_overrun;
        test_back_to_back;
        test_false_start;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
